// File: rtl/seg7_scan_reader_if.sv
// Multiplexed active-low 7-segment display bus: digit enables plus shared segment lines.
// The master drives the display; the scan reader observes it as a slave.
interface seg7_scan_reader_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0] digit_sel_n;
    logic [6:0]            segments_n;

    modport master (output digit_sel_n, output segments_n);
    modport slave  (input  digit_sel_n, input  segments_n);
endinterface

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed active-low 7-segment bus, qualifies each slot over a stability
// window, decodes the segments to hex and publishes a frame once every slot has been seen.
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    seg7_scan_reader_if.slave       disp,
    input  logic                    err_clear,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    frame_valid,
    output logic                    err_out
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_ONES = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] ALL_ZERO = {NUM_DIGITS{1'b0}};

    typedef enum logic [0:0] {
        ST_SETTLING = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Result packing is {invalid, blank, value}.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h01:   decode_seg = {2'b00, 4'h0};
            7'h4f:   decode_seg = {2'b00, 4'h1};
            7'h12:   decode_seg = {2'b00, 4'h2};
            7'h06:   decode_seg = {2'b00, 4'h3};
            7'h4c:   decode_seg = {2'b00, 4'h4};
            7'h24:   decode_seg = {2'b00, 4'h5};
            7'h20:   decode_seg = {2'b00, 4'h6};
            7'h0f:   decode_seg = {2'b00, 4'h7};
            7'h00:   decode_seg = {2'b00, 4'h8};
            7'h04:   decode_seg = {2'b00, 4'h9};
            7'h08:   decode_seg = {2'b00, 4'hA};
            7'h60:   decode_seg = {2'b00, 4'hB};
            7'h31:   decode_seg = {2'b00, 4'hC};
            7'h42:   decode_seg = {2'b00, 4'hD};
            7'h30:   decode_seg = {2'b00, 4'hE};
            7'h38:   decode_seg = {2'b00, 4'hF};
            7'h7f:   decode_seg = {2'b01, 4'h0};
            default: decode_seg = {2'b10, 4'h0};
        endcase
    endfunction

    function automatic logic one_low(input logic [NUM_DIGITS-1:0] sel_n);
        logic [NUM_DIGITS-1:0] act;
        act     = ~sel_n;
        one_low = (act != ALL_ZERO) && ((act & (act - NUM_DIGITS'(1))) == ALL_ZERO);
    endfunction

    logic [NUM_DIGITS-1:0]   sel_q_r;
    logic [6:0]              seg_q_r;
    logic [CNT_W-1:0]        cnt_r;
    state_t                  state_r;
    logic [NUM_DIGITS-1:0]   mask_r;
    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic [NUM_DIGITS-1:0]   shadow_blank_r;

    logic                    same_s;
    logic [CNT_W-1:0]        cnt_s;
    state_t                  state_s;
    logic                    capture_s;
    logic [5:0]              dec_s;
    logic [NUM_DIGITS-1:0]   cap_mask_s;
    logic [NUM_DIGITS-1:0]   mask_s;
    logic [4*NUM_DIGITS-1:0] shadow_s;
    logic [NUM_DIGITS-1:0]   shadow_blank_s;
    logic                    frame_done_s;

    // Stability counting, capture decision and next FSM state.
    always_comb begin
        same_s    = (disp.digit_sel_n == sel_q_r) && (disp.segments_n == seg_q_r);
        cnt_s     = {CNT_W{1'b0}};
        state_s   = state_r;
        capture_s = (state_r == ST_SETTLING) && (cnt_r == CNT_MAX) && one_low(sel_q_r);
        if (same_s) begin
            cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
        end else begin
            cnt_s = {CNT_W{1'b0}};
        end
        // A changing sample always re-arms, even on the edge that captures the old slot.
        if (!same_s) begin
            state_s = ST_SETTLING;
        end else if (capture_s) begin
            state_s = ST_LOCKED;
        end else begin
            state_s = state_r;
        end
    end

    // Shadow update and frame completion for the slot being captured this cycle.
    always_comb begin
        dec_s          = decode_seg(seg_q_r);
        cap_mask_s     = capture_s ? ~sel_q_r : ALL_ZERO;
        shadow_s       = shadow_r;
        shadow_blank_s = shadow_blank_r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask_s[i]) begin
                shadow_s[4*i +: 4] = dec_s[3:0];
                shadow_blank_s[i]  = dec_s[4];
            end else begin
                shadow_s[4*i +: 4] = shadow_r[4*i +: 4];
                shadow_blank_s[i]  = shadow_blank_r[i];
            end
        end
        mask_s       = mask_r | cap_mask_s;
        frame_done_s = capture_s && (mask_s == ALL_ONES);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_SETTLING;
        end else begin
            state_r <= state_s;
        end
    end

    // Sample register, capture bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q_r        <= ALL_ONES;
            seg_q_r        <= 7'h7f;
            cnt_r          <= {CNT_W{1'b0}};
            mask_r         <= ALL_ZERO;
            shadow_r       <= {(4*NUM_DIGITS){1'b0}};
            shadow_blank_r <= ALL_ONES;
            digits_out     <= {(4*NUM_DIGITS){1'b0}};
            blank_out      <= ALL_ONES;
            frame_valid    <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            sel_q_r        <= disp.digit_sel_n;
            seg_q_r        <= disp.segments_n;
            cnt_r          <= cnt_s;
            shadow_r       <= shadow_s;
            shadow_blank_r <= shadow_blank_s;
            frame_valid    <= frame_done_s;
            // Setting wins over a simultaneous clear.
            err_out        <= (capture_s & dec_s[5]) | (err_out & ~err_clear);
            if (frame_done_s) begin
                digits_out <= shadow_s;
                blank_out  <= shadow_blank_s;
                mask_r     <= ALL_ZERO;
            end else begin
                mask_r     <= mask_s;
            end
        end
    end

endmodule
